// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - aluctl code constants and arbiter FSM encoding
package alu_pkg;

    localparam logic [3:0] ALU_OR        = 4'd1;
    localparam logic [3:0] ALU_ADD       = 4'd2;
    localparam logic [3:0] ALU_DXOR      = 4'd5;
    localparam logic [3:0] ALU_SUB       = 4'd6;
    localparam logic [3:0] ALU_SLT       = 4'd7;
    localparam logic [3:0] ALU_ANDOR     = 4'd8;
    localparam logic [3:0] ALU_XORORNOT  = 4'd9;
    localparam logic [3:0] ALU_MULADDMOD = 4'd10;
    localparam logic [3:0] ALU_NOR       = 4'd12;
    localparam logic [3:0] ALU_XOR       = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_multi(input logic [3:0] ctl);
        return ctl == ALU_MULADDMOD;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin grant
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // ptr names the requester that wins a tie; a lone requester always wins
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !ptr)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external ALU between pipeline and scanner requesters
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MULTI_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [3:0]       req0_ctl,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_ctl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             resp0_valid,
    output logic             resp1_valid,
    output logic [WIDTH-1:0] resp_data
);

    localparam logic [3:0] MULTI_CNT = 4'(MULTI_LAT - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       ctl_q, ctl_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic [1:0]       gnt;
    logic [3:0]       sel_ctl;

    rr_arb2 u_rr_arb2 (
        .req ({req1_valid, req0_valid}),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    assign sel_ctl   = gnt[1] ? req1_ctl : req0_ctl;
    assign resp_data = data_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctl_d       = ctl_q;
        a_d         = a_q;
        b_d         = b_q;
        data_d      = data_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        alu_ctl     = 4'd0;
        alu_a       = '0;
        alu_b       = '0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rst_n && gnt != 2'b00) begin
                    req0_ready = gnt[0];
                    req1_ready = gnt[1];
                    owner_d    = gnt[1];
                    ptr_d      = gnt[0];
                    ctl_d      = sel_ctl;
                    a_d        = gnt[1] ? req1_a : req0_a;
                    b_d        = gnt[1] ? req1_b : req0_b;
                    cnt_d      = is_multi(sel_ctl) ? MULTI_CNT : 4'd0;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_ctl = ctl_q;
                alu_a   = a_q;
                alu_b   = b_q;
                if (cnt_q == 4'd0) begin
                    data_d  = alu_result;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                // a reset arriving on the strobe cycle aborts the response too
                resp0_valid = rst_n && !owner_q;
                resp1_valid = rst_n && owner_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ctl_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W  = 32;
    localparam int ML = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0]   req0_ctl = 4'd0, req1_ctl = 4'd0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [3:0]   alu_ctl;
    logic [W-1:0] alu_a, alu_b, alu_result, resp_data;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .MULTI_LAT(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ctl(req0_ctl), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_ctl(req1_ctl), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_data(resp_data)
    );

    function automatic logic [W-1:0] alu_fn(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd1:    return a | b;
            4'd13:   return a ^ b;
            4'd12:   return ~(a | b);
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd10:   return a * b + a;
            default: return a ^ ~b;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_ctl, alu_a, alu_b);

    // Transaction-level reference: one op at a time, scheduled by acceptance cycle.
    bit           m_active = 0, m_prio = 0, m_owner = 0, keep0 = 0;
    int           m_cyc = 0, m_tacc = 0, m_lat = 1, exp_gnt = -1;
    logic [3:0]   m_ctl;
    logic [W-1:0] m_a, m_b;
    int           n_assert = 0, n_fail = 0, n_resp = 0;
    int           glog[$];
    int           rdy_cyc[$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle_check();
        int  d;
        bit  in_exec, in_resp;
        @(negedge clk);
        exp_gnt = -1;
        if (rst_n && !m_active) begin
            if (req0_valid && req1_valid) exp_gnt = m_prio ? 1 : 0;
            else if (req0_valid)          exp_gnt = 0;
            else if (req1_valid)          exp_gnt = 1;
        end
        d       = m_cyc - m_tacc;
        in_exec = m_active && d >= 1 && d <= m_lat;
        in_resp = m_active && d == m_lat + 1;
        chk("req0_ready", W'(req0_ready), W'(exp_gnt == 0));
        chk("req1_ready", W'(req1_ready), W'(exp_gnt == 1));
        chk("alu_ctl", W'(alu_ctl), in_exec ? W'(m_ctl) : '0);
        chk("alu_a", alu_a, in_exec ? m_a : '0);
        chk("alu_b", alu_b, in_exec ? m_b : '0);
        chk("resp0_valid", W'(resp0_valid), W'(rst_n && in_resp && !m_owner));
        chk("resp1_valid", W'(resp1_valid), W'(rst_n && in_resp && m_owner));
        if (rst_n && in_resp) chk("resp_data", resp_data, alu_fn(m_ctl, m_a, m_b));
        if (req0_ready) glog.push_back(0);
        if (req1_ready) glog.push_back(1);
        if (req0_ready) rdy_cyc.push_back(m_cyc);
        if (resp0_valid || resp1_valid) n_resp++;
    endtask

    task automatic step_edge();
        @(posedge clk);
        if (!rst_n) begin
            m_active = 0;
            m_prio   = 0;
        end else if (m_active && m_cyc - m_tacc == m_lat + 1) begin
            m_active = 0;
        end else if (!m_active && exp_gnt >= 0) begin
            m_active = 1;
            m_tacc   = m_cyc;
            m_owner  = (exp_gnt == 1);
            m_prio   = (exp_gnt == 0);
            m_ctl    = m_owner ? req1_ctl : req0_ctl;
            m_a      = m_owner ? req1_a : req0_a;
            m_b      = m_owner ? req1_b : req0_b;
            m_lat    = (m_ctl == 4'd10) ? ML : 1;
        end
        m_cyc++;
        #1;
        if (exp_gnt == 0 && !keep0) req0_valid = 1'b0;
        if (exp_gnt == 1) req1_valid = 1'b0;
        exp_gnt = -1;
    endtask

    task automatic tick();
        settle_check();
        step_edge();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready0", W'(req0_ready), '0);
        chk("rst_ready1", W'(req1_ready), '0);
        chk("rst_alu_ctl", W'(alu_ctl), '0);
        chk("rst_alu_a", alu_a, '0);
        chk("rst_alu_b", alu_b, '0);
        chk("rst_resp0", W'(resp0_valid), '0);
        chk("rst_resp1", W'(resp1_valid), '0);
        chk("rst_resp_data", resp_data, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        settle_check();
        step_edge();
        chk_reset_outputs();
        rst_n = 1'b1;
    endtask

    task automatic set_req0(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        req0_valid = 1'b1; req0_ctl = c; req0_a = a; req0_b = b;
    endtask

    task automatic set_req1(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        req1_valid = 1'b1; req1_ctl = c; req1_a = a; req1_b = b;
    endtask

    initial begin
        int resp_before;
        step_edge();
        step_edge();
        chk_reset_outputs();
        rst_n = 1'b1;

        // single ADD request
        set_req0(ALU_ADD, 32'd5, 32'd7);
        settle_check(); chk("d_single_ready0", W'(req0_ready), 32'd1); step_edge();
        settle_check(); chk("d_single_alu_ctl", W'(alu_ctl), 32'd2); step_edge();
        settle_check(); chk("d_single_resp0", W'(resp0_valid), 32'd1);
        chk("d_single_data", resp_data, 32'd12); step_edge();
        tick();

        // contention after reset, then a second round
        do_reset();
        glog.delete();
        set_req0(ALU_ADD, 32'd1, 32'd2);
        set_req1(ALU_XOR, 32'd3, 32'd4);
        repeat (8) tick();
        chk("cont1_count", W'(glog.size()), 32'd2);
        chk("cont1_first", W'(glog.size() > 0 ? glog[0] : 9), 32'd0);
        chk("cont1_second", W'(glog.size() > 1 ? glog[1] : 9), 32'd1);
        glog.delete();
        set_req0(ALU_OR, 32'h10, 32'h01);
        set_req1(ALU_NOR, 32'h0f, 32'hf0);
        repeat (8) tick();
        chk("cont2_first", W'(glog.size() > 0 ? glog[0] : 9), 32'd0);

        // muladdmod on req1 with req0 waiting behind it
        set_req1(ALU_MULADDMOD, 32'd6, 32'd7);
        settle_check(); chk("multi_ready1", W'(req1_ready), 32'd1); step_edge();
        set_req0(ALU_ADD, 32'd1, 32'd1);
        for (int i = 0; i < ML; i++) begin
            settle_check();
            chk("multi_alu_ctl", W'(alu_ctl), 32'd10);
            chk("multi_no_ready", W'(req0_ready), 32'd0);
            step_edge();
        end
        settle_check();
        chk("multi_resp1", W'(resp1_valid), 32'd1);
        chk("multi_data", resp_data, 32'd48);
        step_edge();
        repeat (4) tick();

        // reset in the middle of a muladdmod
        set_req1(ALU_MULADDMOD, 32'd3, 32'd5);
        tick();
        tick();
        resp_before = n_resp;
        do_reset();
        repeat (4) tick();
        chk("abort_no_resp", W'(n_resp - resp_before), 32'd0);
        glog.delete();
        set_req0(ALU_SUB, 32'd8, 32'd3);
        set_req1(ALU_MULADDMOD, 32'd3, 32'd5);
        repeat (10) tick();
        chk("abort_first", W'(glog.size() > 0 ? glog[0] : 9), 32'd0);

        // back-to-back SUB on req0
        keep0 = 1;
        rdy_cyc.delete();
        set_req0(ALU_SUB, 32'd9, 32'd4);
        repeat (12) tick();
        keep0 = 0;
        req0_valid = 1'b0;
        chk("b2b_count", W'(rdy_cyc.size()), 32'd4);
        for (int i = 1; i < rdy_cyc.size(); i++)
            chk("b2b_spacing", W'(rdy_cyc[i] - rdy_cyc[i-1]), 32'd3);
        repeat (4) tick();

        // randomized traffic with occasional resets
        repeat (400) begin
            if (!req0_valid && $urandom_range(0, 2) == 0)
                set_req0(($urandom_range(0, 3) == 0) ? 4'd10 : 4'($urandom_range(0, 15)), $urandom, $urandom);
            if (!req1_valid && $urandom_range(0, 2) == 0)
                set_req1(($urandom_range(0, 3) == 0) ? 4'd10 : 4'($urandom_range(0, 15)), $urandom, $urandom);
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter MULTI_LAT, default 3, cycles the ALU is held for aluctl 4'd10 (muladdmod), legal range 2..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req0_valid  input  1  pipeline requester has an operation pending.
REQ-006 req0_ctl  input  4  pipeline aluctl code, using the same encoding as the ALU control unit.
REQ-007 req0_a, req0_b  input  WIDTH each  pipeline operands.
REQ-008 req0_ready  output  1  pipeline request accepted this cycle.
REQ-009 req1_valid, req1_ctl[3:0], req1_a, req1_b  input  signature-scanner requester, same meaning as requester 0.
REQ-010 req1_ready  output  1  scanner request accepted this cycle.
REQ-011 alu_ctl  output  4  control code driven to the shared ALU.
REQ-012 alu_a, alu_b  output  WIDTH each  operands driven to the shared ALU.
REQ-013 alu_result  input  WIDTH  shared ALU result.
REQ-014 resp0_valid, resp1_valid  output  1 each  one-cycle result strobe per requester.
REQ-015 resp_data  output  WIDTH  captured result, valid only while a resp*_valid is high.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-017 In IDLE with at least one valid, the block SHALL grant exactly one requester, assert its ready for that cycle only, latch its ctl/a/b, and go to EXEC.
REQ-018 With both requesters valid, the grant SHALL go to the requester not granted last (round-robin); after reset, requester 0 has priority.
REQ-019 A lone valid requester SHALL be granted regardless of the round-robin pointer; the pointer SHALL update only on a grant.
REQ-020 ready SHALL never be asserted outside IDLE, and never for both requesters in the same cycle.
REQ-021 alu_ctl/alu_a/alu_b SHALL be driven from the latched registers, held stable throughout EXEC, and be all-zero in IDLE and RESP.
REQ-022 EXEC SHALL last 1 cycle for every ctl except 4'd10, which SHALL last MULTI_LAT cycles, timed by a 4-bit down-counter.
REQ-023 On the last EXEC cycle, alu_result SHALL be registered into resp_data and the state SHALL advance to RESP.
REQ-024 In RESP, exactly the granted requester's resp*_valid SHALL be high for one cycle; the state SHALL then return to IDLE.
REQ-025 Latency SHALL be acceptance + 2 cycles for single-cycle ops and acceptance + MULTI_LAT + 1 cycles for muladdmod; peak throughput SHALL be one operation per 3 cycles.
REQ-026 Requests arriving while the block is not in IDLE SHALL be ignored until IDLE; requesters hold valid and operands until ready.
REQ-027 Unknown ctl codes SHALL be passed through unchanged and treated as single-cycle.

Reset
REQ-028 While rst_n is low at a clock edge: state=IDLE, counter=0, RR pointer=requester 0, resp_data=0, every output 0.
REQ-029 Reset mid-operation SHALL abort the operation without emitting any resp*_valid; the aborted requester must re-issue it.

Structure
REQ-030 A shared package (alu_pkg) SHALL hold the aluctl code constants (ADD=2, SUB=6, OR=1, XOR=13, NOR=12, SLT=7, DXOR=5, ANDOR=8, MULADDMOD=10, XORORNOT=9) and the FSM state encoding.
REQ-031 The block SHALL contain one sub-module, rr_arb2 (a combinational two-way round-robin grant with pointer input); the ALU itself SHALL be external.

Verification
REQ-032 Single request: req0 ADD a=5, b=7 -> req0_ready at cycle 0, alu_ctl=2 at cycle 1, resp0_valid with resp_data=12 at cycle 2.
REQ-033 Contention: both valid at the same cycle after reset -> req0 granted first, then req1; a second contention round -> req0 granted again (alternation).
REQ-034 Multi-cycle: req1 ctl=10 with MULTI_LAT=3 -> alu_ctl held at 10 for 3 cycles, resp1_valid 4 cycles after acceptance, no ready during that time.
REQ-035 Reset mid-EXEC of a muladdmod: rst_n low for 1 cycle -> no resp*_valid, all outputs 0, the next contention grants req0.
REQ-036 Back-to-back: req0 valid continuously with SUB 9-4 -> ready every 3rd cycle, each resp_data=5, no bubble beyond RESP.
